rx_data_link_layer: RTL and testbench
=====================================

Name: rx_data_link_layer

Overview:
Receive-side data link layer, the counterpart of the TX data link layer. It sits between the physical layer and the transaction layer. It accepts 48-bit frames and checks CRC-8 and the sequence number. In-order good payloads go to the transaction layer through a small buffer. The block returns ack/nack with a sequence number to the link partner's retry buffer.

Parameters:
SEQ_W, 8, sequence-number width (frame bits [47:40]); fixed by frame format.
FIFO_DEPTH, 2, payload buffer entries toward transaction layer (power of 2, >=2).
CNT_W, 16, width of saturating error counters.

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
frame_in  input  48  PHY frame: [47:40] seq, [39:8] TLP data, [7:0] CRC-8
frame_in_valid  input  1  frame_in valid
frame_in_ready  output  1  block can accept a frame
tlp_data_out  output  32  payload to transaction layer
tlp_data_out_valid  output  1  payload valid
tlp_data_out_ready  input  1  transaction layer accepts payload
ack  output  1  one-cycle ack pulse to TX side
nack  output  1  one-cycle nack pulse to TX side
ack_seq  output  8  sequence number qualified by ack/nack
crc_err_cnt  output  CNT_W  saturating count of CRC failures
seq_err_cnt  output  CNT_W  saturating count of out-of-order (ahead) frames

Behaviour:
- Reset (async, active-high): frame_in_ready=0 while reset is asserted, then 1. tlp_data_out_valid=0, tlp_data_out=0, ack=0, nack=0, ack_seq=0, counters=0, exp_seq=0, FIFO empty, state=NORMAL. Reset mid-frame discards the buffered payloads and any pending ack/nack.
- Handshake: a frame is accepted when frame_in_valid & frame_in_ready. frame_in_ready = !fifo_full, taken from registers, with no combinational path from tlp_data_out_ready.
- CRC-8: polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR. It covers frame bits [47:8], MSB first. The frame is good when the computed CRC equals [7:0].
- Classification of an accepted frame, with d = (seq - exp_seq) mod 256:
  - BAD_CRC: CRC mismatch. Sequence field is ignored.
  - IN_ORDER: CRC ok, d==0.
  - DUPLICATE: CRC ok, d in 128..255 (behind exp_seq).
  - AHEAD: CRC ok, d in 1..127.
- FSM states NORMAL and NAK_SCHED:
  - NORMAL, IN_ORDER: push payload, exp_seq+=1 (wraps 255->0), ack with ack_seq=seq.
  - NORMAL, DUPLICATE: drop, ack with ack_seq=exp_seq-1.
  - NORMAL, BAD_CRC: drop, crc_err_cnt+1, nack with ack_seq=exp_seq-1, go to NAK_SCHED.
  - NORMAL, AHEAD: drop, seq_err_cnt+1, nack with ack_seq=exp_seq-1, go to NAK_SCHED.
  - NAK_SCHED, IN_ORDER: same as NORMAL (push, ack), return to NORMAL.
  - NAK_SCHED, DUPLICATE: drop, ack with ack_seq=exp_seq-1, stay.
  - NAK_SCHED, BAD_CRC or AHEAD: drop, increment the counter, no nack, stay.
- Latency: a frame accepted at edge N produces ack/nack/ack_seq registered at N+1, high for exactly one cycle. An IN_ORDER payload is visible on tlp_data_out with valid at N+1. Back-to-back frames produce back-to-back pulses. ack and nack are never both high.
- Payload FIFO: tlp_data_out and tlp_data_out_valid come from the FIFO head. When full, a push and a pop in the same cycle are impossible (ready=0). When not full, push and pop in the same cycle keep the count. Output data stays stable while valid & !ready.
- Counters saturate at all-ones.
- exp_seq wrap: seq 255 followed by seq 0 is in order.

Decomposition:
- Package dll_pkg: SEQ_W, frame bit-field constants (SEQ_MSB/LSB, DATA_MSB/LSB, CRC_MSB/LSB), CRC8_POLY=8'h07, rx_state_e {NORMAL, NAK_SCHED}, frame_class_e {IN_ORDER, DUPLICATE, AHEAD, BAD_CRC}, and a crc8_40b function shared with the TX side.
- One sub-module, dll_rx_fifo: parameterised synchronous FIFO with valid/ready, full and empty outputs.

Test Plan:
- After reset, send seq 0,1,2 with valid CRC and data 32'hA0,A1,A2, ready=1 -> tlp_data_out A0,A1,A2 each one cycle after its frame; ack pulses with ack_seq 0,1,2; no nack.
- Send seq 0 with [7:0] flipped -> nack, ack_seq=8'hFF, crc_err_cnt=1, no payload. Then seq 2 (AHEAD) -> no nack, seq_err_cnt=1. Then good seq 0 -> ack, ack_seq=0, state NORMAL.
- Send seq 0..3, then seq 2 again -> duplicate dropped, ack with ack_seq=3, exp_seq stays 4.
- Hold tlp_data_out_ready=0 and send 3 good frames -> frame_in_ready=0 after 2 accepts, third frame held. Release ready -> all three delivered in order, with no data change while stalled.
- Preload exp_seq to 254 by streaming frames, then send seq 254,255,0 -> all acked with ack_seq 254,255,0 and delivered.
- Assert reset asynchronously mid-stream with 2 payloads buffered -> valid=0 immediately, next good seq 0 accepted and acked with ack_seq=0.

Source files
------------

// File: rtl/dll_pkg.sv
// Shared definitions for the data link layer: frame layout, CRC-8 helper,
// receive FSM states and frame classification codes.
package dll_pkg;

  localparam int SEQ_W    = 8;
  localparam int DATA_W   = 32;
  localparam int FRAME_W  = 48;

  localparam int SEQ_MSB  = 47;
  localparam int SEQ_LSB  = 40;
  localparam int DATA_MSB = 39;
  localparam int DATA_LSB = 8;
  localparam int CRC_MSB  = 7;
  localparam int CRC_LSB  = 0;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic {
    NORMAL,
    NAK_SCHED
  } rx_state_e;

  typedef enum logic [1:0] {
    IN_ORDER,
    DUPLICATE,
    AHEAD,
    BAD_CRC
  } frame_class_e;

  // CRC-8 over the 40 bits of seq + data, MSB first, init 0, no reflection,
  // no final XOR. The TX side uses the same function to generate the trailer.
  function automatic logic [7:0] crc8_40b(input logic [39:0] bits);
    logic [7:0] crc;
    crc = 8'h00;
    for (int i = 39; i >= 0; i--) begin
      if (crc[7] ^ bits[i]) begin
        crc = {crc[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        crc = {crc[6:0], 1'b0};
      end
    end
    return crc;
  endfunction

endpackage

// File: rtl/dll_rx_fifo.sv
// Small synchronous payload FIFO between the link layer and the transaction
// layer. Power-of-two depth so the pointers wrap on their own.
//
// Handshake: a word moves on a rising edge when its valid is high and the
// receiving side is ready; valid never waits on ready, and data is held
// stable while valid is high and ready is low. On the write side "ready"
// is simply !full.
module dll_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx_data_link_layer.sv
// Receive-side data link layer: checks CRC-8 and sequence number of each
// incoming PHY frame, forwards in-order payloads to the transaction layer
// through a small FIFO, and returns ack/nack pulses with a sequence number
// to the partner's retry buffer.
//
// Handshake: frame_in is taken on a rising edge when frame_in_valid and
// frame_in_ready are both high. frame_in_ready depends only on registers
// (reset-release flag and FIFO occupancy), never on tlp_data_out_ready.
module rx_data_link_layer
  import dll_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               frame_in_valid,
  output logic               frame_in_ready,
  output logic [DATA_W-1:0]  tlp_data_out,
  output logic               tlp_data_out_valid,
  input  logic               tlp_data_out_ready,
  output logic               ack,
  output logic               nack,
  output logic [SEQ_W-1:0]   ack_seq,
  output logic [CNT_W-1:0]   crc_err_cnt,
  output logic [CNT_W-1:0]   seq_err_cnt
);

  rx_state_e          state;
  frame_class_e       frame_class;
  logic               alive_q;
  logic [SEQ_W-1:0]   exp_seq;
  logic [SEQ_W-1:0]   rx_seq;
  logic [SEQ_W-1:0]   prev_seq;
  logic [SEQ_W-1:0]   seq_dist;
  logic               crc_ok;
  logic               accept;
  logic               push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_W-1:0]  fifo_data;

  assign rx_seq   = frame_in[SEQ_MSB:SEQ_LSB];
  assign prev_seq = exp_seq - SEQ_W'(1);
  assign seq_dist = rx_seq - exp_seq;
  assign crc_ok   = (crc8_40b(frame_in[SEQ_MSB:DATA_LSB]) == frame_in[CRC_MSB:CRC_LSB]);

  assign frame_in_ready = alive_q && !fifo_full;
  assign accept         = frame_in_valid && frame_in_ready;
  assign push           = accept && (frame_class == IN_ORDER);

  // Classify the frame on the input: CRC first, then the modular distance
  // to exp_seq splits the ring into in-order, behind (duplicate) and ahead.
  always_comb begin
    frame_class = BAD_CRC;
    if (crc_ok) begin
      if (seq_dist == '0) begin
        frame_class = IN_ORDER;
      end else if (seq_dist[SEQ_W-1]) begin
        frame_class = DUPLICATE;
      end else begin
        frame_class = AHEAD;
      end
    end
  end

  // Receive FSM with registered ack/nack, ack_seq, exp_seq and error counters.
  // NAK_SCHED suppresses repeated nacks until an in-order frame arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= NORMAL;
      alive_q     <= 1'b0;
      exp_seq     <= '0;
      ack         <= 1'b0;
      nack        <= 1'b0;
      ack_seq     <= '0;
      crc_err_cnt <= '0;
      seq_err_cnt <= '0;
    end else begin
      alive_q <= 1'b1;
      ack     <= 1'b0;
      nack    <= 1'b0;
      if (accept) begin
        case (frame_class)
          IN_ORDER: begin
            exp_seq <= exp_seq + SEQ_W'(1);
            ack     <= 1'b1;
            ack_seq <= rx_seq;
            state   <= NORMAL;
          end
          DUPLICATE: begin
            ack     <= 1'b1;
            ack_seq <= prev_seq;
          end
          AHEAD: begin
            if (seq_err_cnt != {CNT_W{1'b1}}) begin
              seq_err_cnt <= seq_err_cnt + CNT_W'(1);
            end
            if (state == NORMAL) begin
              nack    <= 1'b1;
              ack_seq <= prev_seq;
              state   <= NAK_SCHED;
            end
          end
          default: begin
            if (crc_err_cnt != {CNT_W{1'b1}}) begin
              crc_err_cnt <= crc_err_cnt + CNT_W'(1);
            end
            if (state == NORMAL) begin
              nack    <= 1'b1;
              ack_seq <= prev_seq;
              state   <= NAK_SCHED;
            end
          end
        endcase
      end
    end
  end

  dll_rx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .in_data   (frame_in[DATA_MSB:DATA_LSB]),
    .in_valid  (push),
    .out_data  (fifo_data),
    .out_valid (tlp_data_out_valid),
    .out_ready (tlp_data_out_ready),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Payload bus reads zero whenever nothing is buffered.
  assign tlp_data_out = fifo_empty ? '0 : fifo_data;

endmodule

// File: tb/tb_rx_data_link_layer.sv
// Bench for rx_data_link_layer: inputs driven 1 time unit after the rising
// edge, outputs sampled on the falling edge. A reference model (CRC by
// polynomial division, sequence rules on integers) predicts every ack/nack
// pulse, counter value and delivered payload.
module tb_rx_data_link_layer;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] frame_in;
  logic        frame_in_valid;
  logic        frame_in_ready;
  logic [31:0] tlp_data_out;
  logic        tlp_data_out_valid;
  logic        tlp_data_out_ready;
  logic        ack;
  logic        nack;
  logic [7:0]  ack_seq;
  logic [15:0] crc_err_cnt;
  logic [15:0] seq_err_cnt;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [31:0] exp_q[$];
  int          m_exp_seq;
  bit          m_nak;
  int          m_crc_cnt;
  int          m_seq_cnt;
  bit          resp_pending;
  bit          resp_ack;
  bit          resp_nack;
  logic [7:0]  resp_seq;

  rx_data_link_layer #(
    .FIFO_DEPTH (2),
    .CNT_W      (16)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .frame_in           (frame_in),
    .frame_in_valid     (frame_in_valid),
    .frame_in_ready     (frame_in_ready),
    .tlp_data_out       (tlp_data_out),
    .tlp_data_out_valid (tlp_data_out_valid),
    .tlp_data_out_ready (tlp_data_out_ready),
    .ack                (ack),
    .nack               (nack),
    .ack_seq            (ack_seq),
    .crc_err_cnt        (crc_err_cnt),
    .seq_err_cnt        (seq_err_cnt)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog time_limit_reached");
    $fatal(1, "timeout");
  end

  // CRC as the remainder of msg * x^8 divided by x^8+x^2+x+1
  function automatic logic [7:0] ref_crc(input logic [39:0] msg);
    logic [47:0] r;
    r = {msg, 8'h00};
    for (int i = 47; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    end
    return r[7:0];
  endfunction

  function automatic logic [47:0] make_frame(input logic [7:0] seq, input logic [31:0] data,
                                             input bit corrupt);
    logic [7:0] c;
    c = ref_crc({seq, data});
    if (corrupt) c = ~c;
    return {seq, data, c};
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_exp_seq    = 0;
    m_nak        = 0;
    m_crc_cnt    = 0;
    m_seq_cnt    = 0;
    resp_pending = 0;
  endtask

  // Apply the link-layer rules to one accepted frame.
  task automatic model_accept(input logic [47:0] f);
    logic [7:0] s;
    int         d;
    s            = f[47:40];
    d            = (int'(s) - m_exp_seq + 256) % 256;
    resp_pending = 1;
    resp_ack     = 0;
    resp_nack    = 0;
    resp_seq     = 8'(m_exp_seq + 255);
    if (ref_crc(f[47:8]) != f[7:0]) begin
      if (m_crc_cnt < 65535) m_crc_cnt++;
      if (!m_nak) begin
        resp_nack = 1;
        m_nak     = 1;
      end
    end else if (d == 0) begin
      exp_q.push_back(f[39:8]);
      resp_ack  = 1;
      resp_seq  = s;
      m_exp_seq = (m_exp_seq + 1) % 256;
      m_nak     = 0;
    end else if (d >= 128) begin
      resp_ack = 1;
    end else begin
      if (m_seq_cnt < 65535) m_seq_cnt++;
      if (!m_nak) begin
        resp_nack = 1;
        m_nak     = 1;
      end
    end
  endtask

  // Driver: present one frame, wait (bounded) for acceptance, update model.
  // Returns 1 time unit after the accepting edge so calls can run back to back.
  task automatic send_frame(input logic [7:0] seq, input logic [31:0] data, input bit corrupt);
    logic [47:0] f;
    int          waited;
    bit          got;
    f              = make_frame(seq, data, corrupt);
    frame_in       = f;
    frame_in_valid = 1'b1;
    waited         = 0;
    got            = 0;
    while (!got && waited < 200) begin
      @(negedge clk);
      if (frame_in_ready === 1'b1) got = 1;
      else waited++;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL accept_timeout seq=%0d ready=%b required=1", seq, frame_in_ready);
      frame_in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_accept(f);
      #1;
      frame_in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);
  endtask

  // Scoreboard / monitor: every falling edge checks payload head and
  // ack/nack pulses against the model.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if (tlp_data_out_valid !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL tlp_valid got=%b exp=%b", tlp_data_out_valid, exp_q.size() != 0);
      end
      if (tlp_data_out_valid === 1'b1 && exp_q.size() != 0) begin
        checks++;
        if (tlp_data_out !== exp_q[0]) begin
          failures++;
          $display("FAIL tlp_data got=%h exp=%h", tlp_data_out, exp_q[0]);
        end
        if (tlp_data_out_ready === 1'b1) void'(exp_q.pop_front());
      end
      checks++;
      if (resp_pending) begin
        if (ack !== resp_ack || nack !== resp_nack ||
            ((resp_ack || resp_nack) && ack_seq !== resp_seq)) begin
          failures++;
          $display("FAIL response got ack=%b nack=%b seq=%0d exp ack=%b nack=%b seq=%0d",
                   ack, nack, ack_seq, resp_ack, resp_nack, resp_seq);
        end
        resp_pending = 0;
      end else if (ack !== 1'b0 || nack !== 1'b0) begin
        failures++;
        $display("FAIL spurious_pulse got ack=%b nack=%b exp 0 0", ack, nack);
      end
      checks++;
      if (crc_err_cnt !== 16'(m_crc_cnt) || seq_err_cnt !== 16'(m_seq_cnt)) begin
        failures++;
        $display("FAIL counters got crc=%0d seq=%0d exp crc=%0d seq=%0d",
                 crc_err_cnt, seq_err_cnt, m_crc_cnt, m_seq_cnt);
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (frame_in_ready !== 1'b0 || tlp_data_out_valid !== 1'b0 || tlp_data_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b valid=%b data=%h exp 0 0 0",
               frame_in_ready, tlp_data_out_valid, tlp_data_out);
    end
    checks++;
    if (ack !== 1'b0 || nack !== 1'b0 || ack_seq !== 8'h00 ||
        crc_err_cnt !== 16'h0 || seq_err_cnt !== 16'h0) begin
      failures++;
      $display("FAIL reset_link got ack=%b nack=%b seq=%h crc=%0d serr=%0d exp all 0",
               ack, nack, ack_seq, crc_err_cnt, seq_err_cnt);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);
    checks++;
    if (frame_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got=%b exp=1", frame_in_ready);
    end
  endtask

  task automatic test_in_order();
    do_reset();
    tlp_data_out_ready = 1'b1;
    send_frame(8'd0, 32'hA0, 0);
    send_frame(8'd1, 32'hA1, 0);
    send_frame(8'd2, 32'hA2, 0);
    idle(3);
  endtask

  task automatic test_errors();
    do_reset();
    send_frame(8'd0, 32'hB0, 1);
    send_frame(8'd2, 32'hB2, 0);
    send_frame(8'd0, 32'hB4, 0);
    idle(2);
    checks++;
    if (crc_err_cnt !== 16'd1 || seq_err_cnt !== 16'd1) begin
      failures++;
      $display("FAIL error_counts got crc=%0d seq=%0d exp 1 1", crc_err_cnt, seq_err_cnt);
    end
    // back in NORMAL: another error must raise a nack again
    send_frame(8'd9, 32'hB9, 0);
    idle(2);
  endtask

  task automatic test_duplicate();
    do_reset();
    for (int s = 0; s < 4; s++) send_frame(8'(s), 32'hD0 + 32'(s), 0);
    send_frame(8'd2, 32'hDD, 0);
    send_frame(8'd4, 32'hD4, 0);
    idle(3);
  endtask

  task automatic test_stall();
    do_reset();
    tlp_data_out_ready = 1'b0;
    send_frame(8'd0, 32'hC0, 0);
    send_frame(8'd1, 32'hC1, 0);
    fork
      send_frame(8'd2, 32'hC2, 0);
      begin
        repeat (4) begin
          @(negedge clk);
          checks++;
          if (frame_in_ready !== 1'b0 || tlp_data_out !== 32'hC0) begin
            failures++;
            $display("FAIL stall_hold got ready=%b data=%h exp 0 c0", frame_in_ready, tlp_data_out);
          end
        end
        @(posedge clk);
        #1;
        tlp_data_out_ready = 1'b1;
      end
    join
    idle(4);
  endtask

  task automatic test_wrap();
    do_reset();
    tlp_data_out_ready = 1'b1;
    for (int s = 0; s < 254; s++) send_frame(8'(s), $urandom, 0);
    send_frame(8'd254, 32'hFE, 0);
    send_frame(8'd255, 32'hFF, 0);
    send_frame(8'd0, 32'h100, 0);
    idle(3);
  endtask

  task automatic test_random();
    bit done;
    done = 0;
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          int kind;
          kind = $urandom_range(0, 9);
          if (kind < 5)       send_frame(8'(m_exp_seq), $urandom, 0);
          else if (kind == 5) send_frame(8'($urandom), $urandom, 1);
          else if (kind < 8)  send_frame(8'(m_exp_seq + $urandom_range(1, 127)), $urandom, 0);
          else                send_frame(8'(m_exp_seq + 256 - $urandom_range(1, 128)), $urandom, 0);
          if ($urandom_range(0, 4) == 0) idle(1);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          tlp_data_out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    tlp_data_out_ready = 1'b1;
    idle(5);
  endtask

  task automatic test_reset_midstream();
    tlp_data_out_ready = 1'b0;
    send_frame(8'(m_exp_seq), 32'hE0, 0);
    send_frame(8'(m_exp_seq), 32'hE1, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_clear();
    #1;
    checks++;
    if (tlp_data_out_valid !== 1'b0 || tlp_data_out !== 32'h0 || frame_in_ready !== 1'b0 ||
        ack !== 1'b0 || nack !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got valid=%b data=%h ready=%b ack=%b nack=%b exp all 0",
               tlp_data_out_valid, tlp_data_out, frame_in_ready, ack, nack);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    tlp_data_out_ready = 1'b1;
    send_frame(8'd0, 32'hE5, 0);
    idle(3);
    checks++;
    if (ack_seq !== 8'd0) begin
      failures++;
      $display("FAIL ack_seq_after_reset got=%0d exp=0", ack_seq);
    end
  endtask

  initial begin
    reset              = 1'b1;
    frame_in           = '0;
    frame_in_valid     = 1'b0;
    tlp_data_out_ready = 1'b0;
    model_clear();
    test_reset();
    test_in_order();
    test_errors();
    test_duplicate();
    test_stall();
    test_wrap();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
